prog_nibble_host: RTL

- Host-side master for the nibble-serial programming port of the nibble CPU.
- Accepts one parallel command (cmd, addr, wdata) per transaction.
- Serializes the command into 13 nibbles on the CPU's nibble input, collects the 8-nibble result stream from the CPU's nibble output, waits for the CPU's done pulse, then returns the result.
- Used as the bench/SoC-side driver; instantiated next to the CPU top.

---
 rtl/prog_nibble_host.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/prog_nibble_host.sv
// Host-side master for the nibble CPU programming port: serializes one command
// into a 13-nibble frame, gathers the result nibbles and reports completion.
module prog_nibble_host #(
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_expect_rsp,
    output logic [3:0]  prog_nibble_in,
    output logic        prog_nibble_in_valid,
    input  logic [3:0]  prog_nibble_out,
    input  logic        prog_out_valid,
    input  logic        prog_done,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [51:0]   frame_q, frame_d;
    logic [3:0]    nib_idx_q, nib_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          expect_q, expect_d;
    logic          done_q, done_d;
    logic [3:0]    rcnt_q, rcnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          tflag_q, tflag_d;

    logic          take_nib;
    logic          done_now;
    logic          complete;
    logic [TW-1:0] tmo_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            nib_idx_q  <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            expect_q   <= 1'b0;
            done_q     <= 1'b0;
            rcnt_q     <= '0;
            shift_q    <= '0;
            rsp_data_q <= '0;
            tflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            nib_idx_q  <= nib_idx_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            expect_q   <= expect_d;
            done_q     <= done_d;
            rcnt_q     <= rcnt_d;
            shift_q    <= shift_d;
            rsp_data_q <= rsp_data_d;
            tflag_q    <= tflag_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        frame_d              = frame_q;
        nib_idx_d            = nib_idx_q;
        gap_d                = gap_q;
        tmo_d                = tmo_q;
        expect_d             = expect_q;
        done_d               = done_q;
        rcnt_d               = rcnt_q;
        shift_d              = shift_q;
        rsp_data_d           = rsp_data_q;
        tflag_d              = tflag_q;
        take_nib             = 1'b0;
        done_now             = 1'b0;
        complete             = 1'b0;
        tmo_next             = '0;
        req_ready            = 1'b0;
        busy                 = 1'b1;
        prog_nibble_in       = 4'h0;
        prog_nibble_in_valid = 1'b0;
        rsp_valid            = 1'b0;
        rsp_timeout          = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    frame_d   = {req_cmd, req_addr, req_wdata};
                    expect_d  = req_expect_rsp;
                    nib_idx_d = 4'd0;
                    gap_d     = '0;
                    state_d   = SEND;
                end
            end

            SEND: begin
                // The frame is shifted out MS nibble first; the gap counter holds off the next one.
                if (gap_q == '0) begin
                    prog_nibble_in_valid = 1'b1;
                    prog_nibble_in       = frame_q[51:48];
                    frame_d              = {frame_q[47:0], 4'h0};
                    if (nib_idx_q == 4'd12) begin
                        state_d = WAIT;
                        tmo_d   = '0;
                        done_d  = 1'b0;
                        rcnt_d  = 4'd0;
                        shift_d = '0;
                    end else begin
                        nib_idx_d = nib_idx_q + 4'd1;
                        gap_d     = GW'(GAP_CYCLES);
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            WAIT: begin
                take_nib = prog_out_valid && expect_q && (rcnt_q != 4'd8);
                if (take_nib) begin
                    shift_d = {shift_q[27:0], prog_nibble_out};
                    rcnt_d  = rcnt_q + 4'd1;
                end
                done_now = done_q || prog_done;
                done_d   = done_now;
                complete = done_now && (!expect_q || (rcnt_d == 4'd8));
                tmo_next = tmo_q + TW'(1);
                tmo_d    = tmo_next;
                // Completion takes priority over a timeout landing in the same cycle.
                if (complete) begin
                    state_d    = RESP;
                    tflag_d    = 1'b0;
                    rsp_data_d = shift_d;
                end else if (tmo_next == TW'(TIMEOUT_CYCLES)) begin
                    state_d    = RESP;
                    tflag_d    = 1'b1;
                    rsp_data_d = shift_d;
                end
            end

            RESP: begin
                rsp_valid   = 1'b1;
                rsp_timeout = tflag_q;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign rsp_data = rsp_data_q;

endmodule
